apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 114 +++++++++++
 tb/tb_apb_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// ============================================================================
//  Module      : apb_master
//  Description : Single-outstanding APB master. Accepts one command at a time
//                over a valid/ready handshake, runs the SETUP/ACCESS phases,
//                and returns a one-cycle response. Aborts with an error if the
//                slave holds PREADY low for TIMEOUT access cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [2:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    // Wait-counter value at which a further PREADY=0 edge aborts the transfer.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    // The master is ready only when no transfer is in flight.
    assign cmd_ready = (state == IDLE);

    // Transfer sequencing with all APB and response outputs registered.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 3'd0;
            PWDATA    <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            // Response is a single-cycle strobe; rdata/err hold until the next one.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        // Completion takes priority over a coincident timeout.
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
                        state     <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= IDLE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
//  Module      : tb_apb_master
//  Description : Directed self-checking bench for apb_master (TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [2:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master #(.TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 3'd6;
        cmd_wdata = 32'hFFFF_FFFF;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;
        step();
        step();
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got psel/pen/pwr/rv/err=%b expected 00000",
                     {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        n_checks++;
        if (PADDR !== 3'd0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got paddr=%0d pwdata=%h rdata=%h expected 0/0/0",
                     PADDR, PWDATA, rsp_rdata);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        step();
        n_checks++;
        if (PSEL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noaccept: got PSEL=%b expected 0", PSEL);
        end
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 3'd2;
        cmd_wdata = 32'hDEAD_BEEF;
        PREADY    = 1'b1;
        step();
        cmd_valid = 1'b0;
        n_checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup: got psel=%b pen=%b pwrite=%b ready=%b expected 1 0 1 0",
                     PSEL, PENABLE, PWRITE, cmd_ready);
        end
        step();
        n_checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 3'd2 || PWDATA !== 32'hDEAD_BEEF
            || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_access: got psel=%b pen=%b paddr=%0d pwdata=%h rv=%b expected 1 1 2 deadbeef 0",
                     PSEL, PENABLE, PADDR, PWDATA, rsp_valid);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || PSEL !== 1'b0
            || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_resp: got rv=%b err=%b rdata=%h psel=%b pen=%b ready=%b expected 1 0 0 0 0 1",
                     rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, cmd_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse: got rv=%b psel=%b expected 0 0", rsp_valid, PSEL);
        end
    endtask

    task automatic test_read_wait();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd2;
        cmd_wdata = 32'h1111_1111;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 3'd2 || PWRITE !== 1'b0
                || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_access%0d: got psel=%b pen=%b paddr=%0d pwrite=%b rv=%b expected 1 1 2 0 0",
                         c, PSEL, PENABLE, PADDR, PWRITE, rsp_valid);
            end
            if (c == 4) begin
                PREADY = 1'b1;
                PRDATA = 32'hDEAD_BEEF;
            end
        end
        step();
        PREADY = 1'b0;
        PRDATA = 32'h0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF || PSEL !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_resp: got rv=%b err=%b rdata=%h psel=%b expected 1 0 deadbeef 0",
                     rsp_valid, rsp_err, rsp_rdata, PSEL);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd_hold: got rv=%b rdata=%h expected 0 deadbeef", rsp_valid, rsp_rdata);
        end
    endtask

    // tie=0: PREADY never rises; tie=1: PREADY rises on the 16th access cycle.
    task automatic test_timeout(input bit tie);
        int cycles;
        cycles    = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd5;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h1234_5678;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                cycles++;
                if (tie && cycles == 16) PREADY = 1'b1;
            end else begin
                break;
            end
        end
        PREADY = 1'b0;
        n_checks++;
        if (cycles !== 16) begin
            n_fail++;
            $display("FAIL to_len(tie=%0d): got %0d access cycles expected 16", tie, cycles);
        end
        n_checks++;
        if (tie) begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678 || PSEL !== 1'b0) begin
                n_fail++;
                $display("FAIL to_tie_resp: got rv=%b err=%b rdata=%h psel=%b expected 1 0 12345678 0",
                         rsp_valid, rsp_err, rsp_rdata, PSEL);
            end
        end else begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 1'b0) begin
                n_fail++;
                $display("FAIL to_resp: got rv=%b err=%b rdata=%h psel=%b expected 1 1 0 0",
                         rsp_valid, rsp_err, rsp_rdata, PSEL);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_psel;
        logic [7:0] exp_rv;
        int setups;
        exp_psel  = 8'b0001_1011;   // bit i = observed cycle i+1
        exp_rv    = 8'b0010_0100;
        setups    = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 3'd3;
        cmd_wdata = 32'hA5A5_A5A5;
        PREADY    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                setups++;
                if (setups == 2) cmd_valid = 1'b0;
            end
            n_checks++;
            if (PSEL !== exp_psel[i] || rsp_valid !== exp_rv[i]) begin
                n_fail++;
                $display("FAIL b2b_cyc%0d: got psel=%b rv=%b expected %b %b",
                         i + 1, PSEL, rsp_valid, exp_psel[i], exp_rv[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: got cmd_ready=%b expected 1", cmd_ready);
                end
            end
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        n_checks++;
        if (setups !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d transfers expected 2", setups);
        end
    endtask

    task automatic test_reset_mid_access();
        int rv_seen;
        rv_seen   = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd4;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got psel=%b pen=%b expected 1 1", PSEL, PENABLE);
        end
        PRESETn = 1'b0;
        step();
        PRESETn = 1'b1;
        n_checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || PADDR !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got psel=%b pen=%b rv=%b paddr=%0d expected 0 0 0 0",
                     PSEL, PENABLE, rsp_valid, PADDR);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            if (rsp_valid === 1'b1) rv_seen++;
        end
        n_checks++;
        if (rv_seen !== 0) begin
            n_fail++;
            $display("FAIL rst_norsp: got %0d responses expected 0", rv_seen);
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 3'd7;
        cmd_wdata = 32'h0BAD_F00D;
        PREADY    = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        n_checks++;
        if (PADDR !== 3'd7 || PWDATA !== 32'h0BAD_F00D || PENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_next_acc: got paddr=%0d pwdata=%h pen=%b expected 7 0badf00d 1",
                     PADDR, PWDATA, PENABLE);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_next_resp: got rv=%b err=%b rdata=%h expected 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        PREADY = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
